// File: rtl/tkmdemo_pkg.sv
// Shared definitions for the tkmdemo TinyTapeout tiles.
// - state_e: control FSM states of the serial arithmetic tiles.
// - Bit positions of the fields packed onto ui_in and uo_out.
package tkmdemo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // ui_in field positions
    localparam int A_BIT     = 0;
    localparam int B_BIT     = 1;
    localparam int VALID_BIT = 2;
    localparam int START_BIT = 3;

    // uo_out field positions (bit count occupies [7:4])
    localparam int DIFF_BIT   = 0;
    localparam int BORROW_BIT = 1;
    localparam int DONE_BIT   = 2;
    localparam int BUSY_BIT   = 3;
    localparam int CNT_LSB    = 4;

endpackage

// File: rtl/serial_sub_cell.sv
// One-bit full-subtractor slice: d = a - b - bin, with borrow out.
// Ports:
//   a_i, b_i   operand bits
//   bin_i      borrow in
//   d_o        difference bit
//   bout_o     borrow out
module serial_sub_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    // Borrow when b exceeds a, or when they are equal and a borrow is pending.
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/tt_um_tkmdemo_serial_sub.sv
// Bit-serial WIDTH-bit subtractor (A - B), operands LSB-first, in the
// TinyTapeout tile wrapper.
// Ports:
//   clk, rst_n  tile clock, asynchronous active-low reset
//   ena         tile enable; when low every register holds
//   ui_in       [0]=a_bit [1]=b_bit [2]=bit_valid [3]=start, [7:4] unused
//   uo_out      [0]=diff_bit [1]=borrow [2]=done [3]=busy [7:4]=bit_count
//   uio_in      unused
//   uio_out     completed difference word, zero-extended
//   uio_oe      constant all-outputs
module tt_um_tkmdemo_serial_sub
    import tkmdemo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [3:0] LAST_CNT = 4'(WIDTH - 1);

    state_e           state_q;
    logic             borrow_q;
    logic             diff_q;
    logic             done_q;
    logic             busy_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;
    logic [WIDTH-1:0] res_q;
    logic [7:0]       res_ext;

    logic a_bit, b_bit, bit_valid, start;
    logic d, bout;

    assign a_bit     = ui_in[A_BIT];
    assign b_bit     = ui_in[B_BIT];
    assign bit_valid = ui_in[VALID_BIT];
    assign start     = ui_in[START_BIT];

    serial_sub_cell u_cell (
        .a_i    (a_bit),
        .b_i    (b_bit),
        .bin_i  (borrow_q),
        .d_o    (d),
        .bout_o (bout)
    );

    // Right shift with the new difference bit entering at the MSB, so the
    // word is LSB-aligned once WIDTH bits have been accepted. Written as a
    // shift plus bit-set so WIDTH=1 needs no special slice.
    always_comb begin
        sh_d            = sh_q >> 1;
        sh_d[WIDTH-1]   = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            borrow_q <= 1'b0;
            diff_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            sh_q     <= '0;
            res_q    <= '0;
        end else if (ena) begin
            if (start) begin
                // Start wins over a coincident bit; result keeps the last word.
                state_q  <= RUN;
                borrow_q <= 1'b0;
                diff_q   <= 1'b0;
                done_q   <= 1'b0;
                busy_q   <= 1'b1;
                cnt_q    <= '0;
                sh_q     <= '0;
            end else if (state_q == RUN && bit_valid) begin
                diff_q   <= d;
                borrow_q <= bout;
                sh_q     <= sh_d;
                if (cnt_q == LAST_CNT) begin
                    res_q   <= sh_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= DONE;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end
        end
    end

    always_comb begin
        res_ext             = '0;
        res_ext[WIDTH-1:0]  = res_q;
    end

    assign uo_out  = {cnt_q, busy_q, done_q, borrow_q, diff_q};
    assign uio_out = res_ext;
    assign uio_oe  = 8'hFF;

    logic unused_inputs;
    assign unused_inputs = ^{uio_in, ui_in[7:4]};

endmodule
